// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch front end.
//
// Owns the architectural fetch PC, runs a single-outstanding request/response
// handshake on the instruction bus and hands one {pc, instruction} pair at a
// time to the fetch stage. Redirects from later stages take priority over every
// other event; a response that belongs to a request issued before a redirect is
// discarded.
//
// Optional build macro IFETCH_SKID_BUF_EN: adds a 1-entry skid buffer so the
// next sequential fetch overlaps with a stalled output. Without it the next
// request issues only after the held output has been accepted.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   redirect_valid/pc load a new fetch PC (highest priority)
//   ireq_valid/addr   instruction bus request (address stable until response)
//   iresp_data_ok     response strobe completing the outstanding request
//   iresp_data        returned instruction word
//   out_valid/ready   handshake to the fetch stage
//   out_pc/out_instr  delivered PC and instruction (registered)
module ifetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StHold  = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] stale_q, stale_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        pc_aligned;

`ifdef IFETCH_SKID_BUF_EN
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        resp_hold;
`endif

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  // Bus request. Gated by reset so the bus is quiet while reset is held.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = 64'h0;
    if (!reset) begin
      case (state_q)
        StReq: begin
          ireq_valid = pc_aligned;
          ireq_addr  = pc_q;
        end
        StHold: begin
`ifdef IFETCH_SKID_BUF_EN
          ireq_valid = pc_aligned & ~skid_valid_q;
          ireq_addr  = pc_q;
`endif
        end
        StFlush: begin
          // Stale request still owns the bus; keep its address stable.
          ireq_valid = 1'b1;
          ireq_addr  = stale_q;
        end
        default: begin
          ireq_valid = 1'b0;
          ireq_addr  = 64'h0;
        end
      endcase
    end
  end

`ifdef IFETCH_SKID_BUF_EN
  assign resp_hold = iresp_data_ok & ireq_valid;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
`ifdef IFETCH_SKID_BUF_EN
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
`ifdef IFETCH_SKID_BUF_EN
      skid_valid_d = 1'b0;
`endif
      if (state_q == StFlush) begin
        state_d = iresp_data_ok ? StReq : StFlush;
      end else if (ireq_valid && !iresp_data_ok) begin
        // Outstanding request to pc_q must still be drained off the bus.
        state_d = StFlush;
        stale_d = pc_q;
      end else begin
        state_d = StReq;
      end
    end else begin
      case (state_q)
        StReq: begin
          if (!pc_aligned) begin
            // No bus access; deliver a marker the fetch stage turns into a trap.
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = 32'h0;
            state_d     = StHold;
          end else if (iresp_data_ok) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = iresp_data;
            pc_d        = pc_q + 64'd4;
            state_d     = StHold;
          end
        end
        StHold: begin
`ifdef IFETCH_SKID_BUF_EN
          if (out_ready) begin
            if (skid_valid_q) begin
              out_pc_d     = skid_pc_q;
              out_instr_d  = skid_instr_q;
              skid_valid_d = 1'b0;
            end else if (resp_hold) begin
              out_pc_d    = pc_q;
              out_instr_d = iresp_data;
              pc_d        = pc_q + 64'd4;
            end else begin
              // Any overlapped request to pc_q simply continues in StReq.
              out_valid_d = 1'b0;
              state_d     = StReq;
            end
          end else if (resp_hold) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = iresp_data;
            pc_d         = pc_q + 64'd4;
          end
`else
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StReq;
          end
`endif
        end
        StFlush: begin
          if (iresp_data_ok) begin
            state_d = StReq;
          end
        end
        default: begin
          state_d = StReq;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= PC_RESET;
      stale_q     <= 64'h0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 64'h0;
      out_instr_q <= 32'h0;
`ifdef IFETCH_SKID_BUF_EN
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 64'h0;
      skid_instr_q <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stale_q     <= stale_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
`ifdef IFETCH_SKID_BUF_EN
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: an instruction-bus responder with configurable
// latency, a scoreboard of expected {pc, instr} transfers checked at every
// out_valid & out_ready handshake, and one task per scenario.
module tb_ifetch_ctrl;

  localparam logic [63:0] PcReset = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int vectors;
  int miscompares;
  int bus_lat;
  int req_count;
  int base_req;
  logic [95:0] exp_q[$];

  ifetch_ctrl #(
    .PC_RESET(PcReset)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  // Bus responder: one outstanding request, answers bus_lat cycles after it starts.
  initial begin
    logic [63:0] hold_addr;
    int          wait_cnt;
    bit          busy;
    busy          = 1'b0;
    wait_cnt      = 0;
    hold_addr     = 64'h0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    forever begin
      @(posedge clk);
      #3;
      iresp_data_ok = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else if (busy) begin
        vectors++;
        if (ireq_valid !== 1'b1 || ireq_addr !== hold_addr) begin
          $display("FAIL bus_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                   ireq_valid, ireq_addr, hold_addr);
          miscompares++;
        end
        wait_cnt++;
        if (wait_cnt >= bus_lat) begin
          iresp_data_ok = 1'b1;
          iresp_data    = instr_of(hold_addr);
          busy          = 1'b0;
        end
      end else if (ireq_valid === 1'b1) begin
        busy      = 1'b1;
        hold_addr = ireq_addr;
        wait_cnt  = 0;
        req_count++;
      end
    end
  end

  // Scoreboard: every accepted output must match the oldest expectation.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid !== 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got pc=%h instr=%h, required no transfer",
                   out_pc, out_instr);
          miscompares++;
        end else begin
          e = exp_q.pop_front();
          if ({out_pc, out_instr} !== e) begin
            $display("FAIL out_pair: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, e[95:32], e[31:0]);
            miscompares++;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    base_req = req_count;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b0) begin
      $display("FAIL rst_ireq_valid: got %b, required 0", ireq_valid); miscompares++;
    end
    vectors++;
    if (ireq_addr !== 64'h0) begin
      $display("FAIL rst_ireq_addr: got %h, required 0", ireq_addr); miscompares++;
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_out_valid: got %b, required 0", out_valid); miscompares++;
    end
    vectors++;
    if (out_pc !== 64'h0) begin
      $display("FAIL rst_out_pc: got %h, required 0", out_pc); miscompares++;
    end
    vectors++;
    if (out_instr !== 32'h0) begin
      $display("FAIL rst_out_instr: got %h, required 0", out_instr); miscompares++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b1 || ireq_addr !== PcReset) begin
      $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=%h",
               ireq_valid, ireq_addr, PcReset);
      miscompares++;
    end
  endtask

  task automatic test_seq_fetch();
    int n;
    bus_lat = 1;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({PcReset + 64'(4 * i), instr_of(PcReset + 64'(4 * i))});
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL seq_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    int extra;
    bus_lat = 1;
    apply_reset();
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== PcReset || out_instr !== instr_of(PcReset)) begin
        $display("FAIL stall_hold: got valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 out_valid, out_pc, out_instr, PcReset, instr_of(PcReset));
        miscompares++;
      end
      @(negedge clk);
    end
`ifdef IFETCH_SKID_BUF_EN
    extra = 2;
`else
    extra = 1;
`endif
    vectors++;
    if (req_count - base_req != extra) begin
      $display("FAIL stall_requests: got %0d, required %0d", req_count - base_req, extra);
      miscompares++;
    end
    @(posedge clk);
    #1;
    exp_q.push_back({PcReset, instr_of(PcReset)});
    exp_q.push_back({PcReset + 64'd4, instr_of(PcReset + 64'd4)});
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    int n;
    bus_lat = 3;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({PcReset + 64'(4 * i), instr_of(PcReset + 64'(4 * i))});
    end
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL redir_pre_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin
      $display("FAIL redir_pending: got valid=%b addr=%h, required valid=1 addr=0000000080000010",
               ireq_valid, ireq_addr);
      miscompares++;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    @(posedge clk); #1;
    redirect_pc    = 64'h8000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin
      $display("FAIL redir_stale_addr: got valid=%b addr=%h, required valid=1 addr=0000000080000010",
               ireq_valid, ireq_addr);
      miscompares++;
    end
    n = 0;
    while (!(ireq_valid === 1'b1 && ireq_addr !== 64'h8000_0010) && n < 10) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (ireq_addr !== 64'h8000_0100) begin
      $display("FAIL redir_next_req: got %h, required 0000000080000100", ireq_addr);
      miscompares++;
    end
    @(posedge clk); #1;
    exp_q.push_back({64'h8000_0100, instr_of(64'h8000_0100)});
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL redir_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_data_ok_hold();
    int n;
    bus_lat = 2;
    apply_reset();
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (iresp_data_ok !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.push_back({64'h8000_0200, instr_of(64'h8000_0200)});
    exp_q.push_back({64'h8000_0204, instr_of(64'h8000_0204)});
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0208) begin
      $display("FAIL hold_pc: got valid=%b pc=%h, required valid=1 pc=0000000080000208",
               out_valid, out_pc);
      miscompares++;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL hold_drop: got out_valid=%b, required 0", out_valid);
      miscompares++;
    end
    @(posedge clk); #1;
    exp_q.push_back({64'h8000_0200, instr_of(64'h8000_0200)});
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL hold_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_misaligned_wrap();
    int n;
    bus_lat = 1;
    apply_reset();
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0002;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b0) begin
      $display("FAIL mis_no_req: got ireq_valid=%b, required 0", ireq_valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0002 || out_instr !== 32'h0 ||
        ireq_valid !== 1'b0) begin
      $display("FAIL mis_out: got valid=%b pc=%h instr=%h req=%b, required valid=1 pc=0000000080000002 instr=0 req=0",
               out_valid, out_pc, out_instr, ireq_valid);
      miscompares++;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, instr_of(64'hFFFF_FFFF_FFFF_FFFC)});
    exp_q.push_back({64'h0, instr_of(64'h0)});
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      $display("FAIL wrap_top_req: got valid=%b addr=%h, required valid=1 addr=fffffffffffffffc",
               ireq_valid, ireq_addr);
      miscompares++;
    end
    n = 0;
    while (!(ireq_valid === 1'b1 && ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) && n < 20) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin
      $display("FAIL wrap_next_req: got valid=%b addr=%h, required valid=1 addr=0",
               ireq_valid, ireq_addr);
      miscompares++;
    end
    @(posedge clk); #1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size());
      miscompares++; exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    bus_lat        = 1;
    req_count      = 0;
    base_req       = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    test_reset();
    test_seq_fetch();
    test_stall();
    test_redirect_outstanding();
    test_redirect_data_ok_hold();
    test_misaligned_wrap();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
